bft_leaf_arbiter: RTL and testbench
===================================

Name: bft_leaf_arbiter

Overview:
- Injection controller for one BFT leaf port.
- Shares the leaf's single network ingress (pe_interface) between NUM_REQ local requesters using round-robin arbitration.
- Sequences each packet through present/accept/retry, with a back-off after every resend.
- Registers the leaf's egress stream (interface_pe) for local consumers and keeps transmit/retry statistics.

Parameters:
- NUM_LEAVES, 8, number of tree leaves; LA = $clog2(NUM_LEAVES) is the address width.
- PAYLOAD_SZ, LA+4, payload width.
- P_SZ, 1+LA+PAYLOAD_SZ, packet width; any other value is illegal.
- NUM_REQ, 4, number of local requesters (>=2).
- BACKOFF, 2, idle cycles after a resend before the packet is re-presented; 0 means re-present the next cycle.
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  permits new grants.
- req_valid  in  NUM_REQ  per-requester packet valid.
- req_dest  in  NUM_REQ*LA  per-requester destination leaf; slice i is [i*LA +: LA].
- req_payload  in  NUM_REQ*PAYLOAD_SZ  per-requester payload; slice i is [i*PAYLOAD_SZ +: PAYLOAD_SZ].
- req_ready  out  NUM_REQ  one-hot accept (combinational).
- pe_interface  out  P_SZ  packet to network: [P_SZ-1] valid, [P_SZ-2:PAYLOAD_SZ] dest, [PAYLOAD_SZ-1:0] payload.
- interface_pe  in  P_SZ  packet from network, same layout.
- resend  in  1  network rejects the packet currently on pe_interface.
- rx_valid  out  1  egress packet valid (registered).
- rx_dest  out  LA  egress destination field.
- rx_payload  out  PAYLOAD_SZ  egress payload.
- busy  out  1  state != IDLE.
- tx_count  out  CNT_W  packets accepted by the network.
- retry_count  out  CNT_W  resends received.

Behaviour:
- Reset (async): state=IDLE; pe_interface=0; rx_valid=0; rx_dest=0; rx_payload=0; tx_count=0; retry_count=0; busy=0; rr_ptr=NUM_REQ-1, so req 0 has first priority.
- Arbitration:
  - The winner is the first i with req_valid[i]=1, searching from rr_ptr+1 and wrapping modulo NUM_REQ.
  - load_ok = enable & (state==IDLE | (state==SEND & !resend)).
  - req_ready[winner] = load_ok & any req_valid; all other bits are 0.
  - The handshake completes at the clock edge where req_valid[i] & req_ready[i] are both 1.
  - On that edge the {1, dest, payload} packet is latched into pe_interface, rr_ptr<=winner, and state<=SEND.
  - Latency: a request accepted at edge t appears on pe_interface in cycle t+1.
- States:
  - IDLE: pe_interface valid bit = 0, data bits hold their last value. A grant moves to SEND.
  - SEND: pe_interface holds the valid packet. At each edge:
    - resend=0: accepted; tx_count++ (saturating). If a grant occurs this cycle (back-to-back, one packet per cycle), stay in SEND with the new packet; else go to IDLE and clear the valid bit.
    - resend=1: rejected; retry_count++ (saturating). If BACKOFF=0, stay in SEND with the identical packet. Else go to BACKOFF, clear the valid bit, keep dest/payload, and set bo_cnt=BACKOFF-1.
  - BACKOFF: valid bit = 0; bo_cnt decrements each cycle. When bo_cnt==0, re-present the identical packet and return to SEND.
    - No re-arbitration and no req_ready in this state.
    - resend is ignored in this state.
- enable=0 blocks only new grants. A packet already in SEND/BACKOFF completes, including any retries.
- Requester dropping req_valid before ready: nothing is latched and no state changes.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Egress path:
  - Every edge: rx_valid <= interface_pe[P_SZ-1].
  - When that bit is 1, also latch rx_dest and rx_payload; otherwise hold them.
  - Egress runs independently of the injection state.
- Reset asserted mid-operation: the in-flight packet is discarded and nothing is replayed after release.

Test Plan:
- Single request (LA=3, PAYLOAD_SZ=7): req0 valid, dest=5, payload=0x2A, enable=1 -> req_ready=4'b0001 for 1 cycle; next cycle pe_interface=11'h6AA for 1 cycle with resend=0; then pe_interface[10]=0; tx_count=1; busy back to 0.
- All 4 requesters valid continuously, no resend -> grant order 0,1,2,3,0; one packet per cycle with no gaps; tx_count=5 after 5 presentation cycles.
- Reject then accept, BACKOFF=2: resend asserted on the first 2 presentations -> pattern valid, 0, 0, valid, 0, 0, valid; all 3 presentations carry identical bits; retry_count=2; tx_count=1; no extra req_ready pulse.
- enable dropped in the cycle after a grant, with other requests pending -> current packet is accepted; state goes to IDLE; no req_ready until enable returns; the next grant goes to the next round-robin index.
- Egress: interface_pe=11'h6AA for 1 cycle, then 0 -> rx_valid is high for exactly 1 cycle, one cycle later; rx_dest=5 and rx_payload=0x2A, held afterwards.
- reset pulsed during BACKOFF with req1 and req2 pending -> all outputs and counters are 0 immediately; after release the first grant is req1, the lowest valid index from rr_ptr=NUM_REQ-1, and the discarded packet is not replayed.

Source files
------------

// File: rtl/bft_leaf_arbiter_if.sv
// Local-requester and network-port signal bundle for one BFT leaf.
interface bft_leaf_arbiter_if #(
    parameter int NUM_LEAVES = 8,
    parameter int NUM_REQ    = 4
);
    localparam int LA         = $clog2(NUM_LEAVES);
    localparam int PAYLOAD_SZ = LA + 4;
    localparam int P_SZ       = 1 + LA + PAYLOAD_SZ;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*LA-1:0]         req_dest;
    logic [NUM_REQ*PAYLOAD_SZ-1:0] req_payload;
    logic [NUM_REQ-1:0]            req_ready;
    logic [P_SZ-1:0]               pe_interface;
    logic [P_SZ-1:0]               interface_pe;
    logic                          resend;
    logic                          rx_valid;
    logic [LA-1:0]                 rx_dest;
    logic [PAYLOAD_SZ-1:0]         rx_payload;

    modport master (
        output req_valid, req_dest, req_payload, interface_pe, resend,
        input  req_ready, pe_interface, rx_valid, rx_dest, rx_payload
    );

    modport slave (
        input  req_valid, req_dest, req_payload, interface_pe, resend,
        output req_ready, pe_interface, rx_valid, rx_dest, rx_payload
    );
endinterface

// File: rtl/bft_leaf_arbiter.sv
// Round-robin injection controller for one BFT leaf, with registered egress and tx/retry stats.
// Latency: grant at edge t -> packet on pe_interface in cycle t+1; egress is one register stage.
// Backpressure: resend rejects the presented packet; it is re-presented after BACKOFF idle cycles.
module bft_leaf_arbiter #(
    parameter int NUM_LEAVES = 8,
    parameter int NUM_REQ    = 4,
    parameter int BACKOFF    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    bft_leaf_arbiter_if.slave    bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     tx_count,
    output logic [CNT_W-1:0]     retry_count
);
    localparam int LA         = $clog2(NUM_LEAVES);
    localparam int PAYLOAD_SZ = LA + 4;
    localparam int RW         = $clog2(NUM_REQ);
    localparam int BW         = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_BACKOFF} state_t;

    state_t                state, state_nxt;
    logic                  pkt_vld, pkt_vld_nxt;
    logic [LA-1:0]         pkt_dest;
    logic [PAYLOAD_SZ-1:0] pkt_payload;
    logic [BW-1:0]         bo_cnt;
    logic [RW-1:0]         rr_ptr, winner, idx;
    logic                  any_req, load_ok, grant, load, bo_load;
    logic [LA-1:0]         sel_dest;
    logic [PAYLOAD_SZ-1:0] sel_payload;

    // Rotating priority: search starts just after the last winner.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = RW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_req && bus.req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_comb begin
        sel_dest    = '0;
        sel_payload = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == RW'(i)) begin
                sel_dest    = bus.req_dest[i*LA +: LA];
                sel_payload = bus.req_payload[i*PAYLOAD_SZ +: PAYLOAD_SZ];
            end
        end
    end

    // Reset gating keeps req_ready low while the block is held in reset.
    assign load_ok = enable & ~reset &
                     ((state == S_IDLE) | ((state == S_SEND) & ~bus.resend));
    assign grant   = load_ok & any_req;

    always_comb begin
        bus.req_ready = '0;
        if (grant) bus.req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        pkt_vld_nxt = pkt_vld;
        load        = 1'b0;
        bo_load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt   = S_SEND;
                    pkt_vld_nxt = 1'b1;
                    load        = 1'b1;
                end
            end
            S_SEND: begin
                if (!bus.resend) begin
                    if (grant) begin
                        load = 1'b1;
                    end else begin
                        state_nxt   = S_IDLE;
                        pkt_vld_nxt = 1'b0;
                    end
                end else if (BACKOFF != 0) begin
                    state_nxt   = S_BACKOFF;
                    pkt_vld_nxt = 1'b0;
                    bo_load     = 1'b1;
                end
            end
            S_BACKOFF: begin
                if (bo_cnt == '0) begin
                    state_nxt   = S_SEND;
                    pkt_vld_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                pkt_vld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pkt_vld     <= 1'b0;
            pkt_dest    <= '0;
            pkt_payload <= '0;
            bo_cnt      <= '0;
            rr_ptr      <= RW'(NUM_REQ - 1);
            tx_count    <= '0;
            retry_count <= '0;
        end else begin
            state   <= state_nxt;
            pkt_vld <= pkt_vld_nxt;
            if (load) begin
                pkt_dest    <= sel_dest;
                pkt_payload <= sel_payload;
                rr_ptr      <= winner;
            end
            if (bo_load)
                bo_cnt <= BW'(BACKOFF - 1);
            else if (state == S_BACKOFF && bo_cnt != '0)
                bo_cnt <= bo_cnt - 1'b1;
            if (state == S_SEND && !bus.resend && tx_count != '1)
                tx_count <= tx_count + 1'b1;
            if (state == S_SEND && bus.resend && retry_count != '1)
                retry_count <= retry_count + 1'b1;
        end
    end

    // Egress capture is independent of the injection FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rx_valid   <= 1'b0;
            bus.rx_dest    <= '0;
            bus.rx_payload <= '0;
        end else begin
            bus.rx_valid <= bus.interface_pe[1+LA+PAYLOAD_SZ-1];
            if (bus.interface_pe[1+LA+PAYLOAD_SZ-1]) begin
                bus.rx_dest    <= bus.interface_pe[LA+PAYLOAD_SZ-1:PAYLOAD_SZ];
                bus.rx_payload <= bus.interface_pe[PAYLOAD_SZ-1:0];
            end
        end
    end

    assign bus.pe_interface = {pkt_vld, pkt_dest, pkt_payload};
    assign busy             = (state != S_IDLE);
endmodule

// File: tb/tb_bft_leaf_arbiter.sv
// Bench for bft_leaf_arbiter: directed vector table, corner sequences, then random traffic vs. a reference model.
module tb_bft_leaf_arbiter;
    localparam int NUM_LEAVES = 8;
    localparam int NUM_REQ    = 4;
    localparam int BACKOFF    = 2;
    localparam int CNT_W      = 4;
    localparam int LA         = 3;
    localparam int PL         = 7;
    localparam int P_SZ       = 11;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             busy;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] retry_count;

    bft_leaf_arbiter_if #(.NUM_LEAVES(NUM_LEAVES), .NUM_REQ(NUM_REQ)) bus();

    bft_leaf_arbiter #(
        .NUM_LEAVES(NUM_LEAVES), .NUM_REQ(NUM_REQ), .BACKOFF(BACKOFF), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus.slave),
        .busy(busy), .tx_count(tx_count), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [LA-1:0] fdest [NUM_REQ] = '{3'd5, 3'd1, 3'd2, 3'd3};
    logic [PL-1:0] fpay  [NUM_REQ] = '{7'h2A, 7'h11, 7'h22, 7'h33};

    task automatic apply(input logic [3:0] rv, input logic en, input logic rs, input logic [P_SZ-1:0] ipe);
        bus.req_valid = rv;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_dest[i*LA +: LA]    = fdest[i];
            bus.req_payload[i*PL +: PL] = fpay[i];
        end
        enable           = en;
        bus.resend       = rs;
        bus.interface_pe = ipe;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]      rv;
        logic            en;
        logic            rs;
        logic [P_SZ-1:0] ipe;
        logic [3:0]      ready;
        logic [P_SZ-1:0] pe;
        logic            busy;
        logic            rxv;
        int              tx;
        int              rt;
    } vec_t;

    vec_t tbl [11];

    // Reference model state: packet held, idle cycles left before re-presenting, last winner.
    int              m_have, m_wait, m_rr, m_tx, m_rt;
    logic [LA-1:0]   m_dest, m_rxd;
    logic [PL-1:0]   m_pay, m_rxp;
    logic            m_rxv;

    task automatic model_reset();
        m_have = 0; m_wait = 0; m_rr = NUM_REQ - 1; m_tx = 0; m_rt = 0;
        m_dest = '0; m_pay = '0; m_rxv = 1'b0; m_rxd = '0; m_rxp = '0;
    endtask

    initial begin
        int present, can, w;
        logic [3:0] exp_ready;
        logic [P_SZ-1:0] exp_pe;

        tbl[0]  = '{4'b0001, 1'b1, 1'b0, 11'h6AA & 11'h000, 4'b0001, 11'h000, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 11'h6AA, 4'b0000, 11'h6AA, 1'b1, 1'b0, 0, 0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 11'h000, 4'b0000, 11'h2AA, 1'b0, 1'b1, 1, 0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b0, 11'h000, 4'b0010, 11'h2AA, 1'b0, 1'b0, 1, 0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 11'h000, 4'b0100, 11'h491, 1'b1, 1'b0, 1, 0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 11'h000, 4'b0000, 11'h522, 1'b1, 1'b0, 2, 0};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 11'h000, 4'b0000, 11'h122, 1'b1, 1'b0, 2, 1};
        tbl[7]  = '{4'b1111, 1'b1, 1'b0, 11'h000, 4'b0000, 11'h122, 1'b1, 1'b0, 2, 1};
        tbl[8]  = '{4'b1111, 1'b0, 1'b0, 11'h000, 4'b0000, 11'h522, 1'b1, 1'b0, 2, 1};
        tbl[9]  = '{4'b1111, 1'b0, 1'b0, 11'h000, 4'b0000, 11'h122, 1'b0, 1'b0, 3, 1};
        tbl[10] = '{4'b1111, 1'b1, 1'b0, 11'h000, 4'b1000, 11'h122, 1'b0, 1'b0, 3, 1};

        reset = 1'b1;
        apply(4'b0000, 1'b0, 1'b0, '0);
        #12;
        chk("reset_pe", 32'(bus.pe_interface), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_tx", 32'(tx_count), 32'h0);
        chk("reset_retry", 32'(retry_count), 32'h0);
        chk("reset_rxv", 32'(bus.rx_valid), 32'h0);
        chk("reset_rx_dest", 32'(bus.rx_dest), 32'h0);
        chk("reset_rx_payload", 32'(bus.rx_payload), 32'h0);
        @(negedge clk) reset = 1'b0;
        step();

        for (int r = 0; r < 11; r++) begin
            apply(tbl[r].rv, tbl[r].en, tbl[r].rs, tbl[r].ipe);
            #1;
            chk($sformatf("vec%0d_ready", r), 32'(bus.req_ready), 32'(tbl[r].ready));
            chk($sformatf("vec%0d_pe", r), 32'(bus.pe_interface), 32'(tbl[r].pe));
            chk($sformatf("vec%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("vec%0d_rxv", r), 32'(bus.rx_valid), 32'(tbl[r].rxv));
            chk($sformatf("vec%0d_tx", r), 32'(tx_count), 32'(tbl[r].tx));
            chk($sformatf("vec%0d_retry", r), 32'(retry_count), 32'(tbl[r].rt));
            step();
        end
        chk("rx_dest_held", 32'(bus.rx_dest), 32'd5);
        chk("rx_payload_held", 32'(bus.rx_payload), 32'h2A);

        // req3's packet is in SEND; reject it, then reset while it waits out the back-off.
        apply(4'b0110, 1'b1, 1'b1, '0);
        #1;
        chk("bo_no_ready", 32'(bus.req_ready), 32'h0);
        step();
        apply(4'b0110, 1'b1, 1'b0, '0);
        #1;
        chk("bo_pe", 32'(bus.pe_interface), 32'h1B3);
        chk("bo_retry", 32'(retry_count), 32'd2);
        reset = 1'b1;
        #1;
        chk("midrst_pe", 32'(bus.pe_interface), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_tx", 32'(tx_count), 32'h0);
        chk("midrst_retry", 32'(retry_count), 32'h0);
        chk("midrst_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("postrst_ready", 32'(bus.req_ready), 32'b0010);
        step();
        chk("postrst_pe", 32'(bus.pe_interface), 32'h491);
        apply(4'b0000, 1'b1, 1'b0, '0);
        step();
        chk("postrst_idle_pe", 32'(bus.pe_interface), 32'h091);
        chk("postrst_tx", 32'(tx_count), 32'd1);
        step();
        chk("no_replay_pe", 32'(bus.pe_interface), 32'h091);
        chk("no_replay_busy", 32'(busy), 32'h0);

        // Continuous contention from all requesters after a fresh reset.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply(4'b1111, 1'b1, 1'b0, '0);
            #1;
            chk($sformatf("rr_order%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            step();
        end
        apply(4'b0000, 1'b1, 1'b0, '0);
        #1;
        chk("rr_last_pe", 32'(bus.pe_interface), 32'h6AA);
        step();
        chk("rr_tx5", 32'(tx_count), 32'd5);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_valid    = 4'($urandom_range(0, 15));
            bus.req_dest     = 12'($urandom);
            bus.req_payload  = 28'($urandom);
            enable           = ($urandom_range(0, 7) != 0);
            bus.resend       = ($urandom_range(0, 2) == 0);
            bus.interface_pe = 11'($urandom);
            #1;
            present   = (m_have != 0 && m_wait == 0) ? 1 : 0;
            can       = (enable && (m_have == 0 || (present != 0 && !bus.resend))) ? 1 : 0;
            w         = -1;
            if (can != 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (w < 0 && bus.req_valid[(m_rr + k) % NUM_REQ]) w = (m_rr + k) % NUM_REQ;
                end
            end
            exp_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
            exp_pe    = {(present != 0), m_dest, m_pay};
            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd_pe", 32'(bus.pe_interface), 32'(exp_pe));
            chk("rnd_busy", 32'(busy), 32'(m_have != 0));
            chk("rnd_tx", 32'(tx_count), 32'(m_tx));
            chk("rnd_retry", 32'(retry_count), 32'(m_rt));
            chk("rnd_rxv", 32'(bus.rx_valid), 32'(m_rxv));
            chk("rnd_rx_dest", 32'(bus.rx_dest), 32'(m_rxd));
            chk("rnd_rx_payload", 32'(bus.rx_payload), 32'(m_rxp));

            if (present != 0) begin
                if (!bus.resend) begin
                    if (m_tx < CMAX) m_tx++;
                    m_have = 0;
                end else begin
                    if (m_rt < CMAX) m_rt++;
                    m_wait = BACKOFF;
                end
            end else if (m_have != 0) begin
                m_wait--;
            end
            if (w >= 0) begin
                m_have = 1;
                m_wait = 0;
                m_dest = bus.req_dest[w*LA +: LA];
                m_pay  = bus.req_payload[w*PL +: PL];
                m_rr   = w;
            end
            m_rxv = bus.interface_pe[P_SZ-1];
            if (m_rxv) begin
                m_rxd = bus.interface_pe[P_SZ-2:PL];
                m_rxp = bus.interface_pe[PL-1:0];
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
